err_metric_accum: RTL
=====================

Name: err_metric_accum

Overview:
Synthesizable error-metric engine for approximate-multiplier characterisation. It consumes a stream of (exact, approximate) product pairs over a valid/ready handshake. For a programmed sample count it accumulates error count, signed and absolute error-distance sums, maximum absolute error and fixed-point relative-error sum. Software or the bench derives ER, MED, MNED and MRED by dividing by the sample count. It sits beside the multiplier under test, so on-chip or emulation runs can replace file-based scoring.

Parameters:
W, 16, width of exact and apprx products (2x multiplier operand width)
CNT_W, 32, width of sample counter and num_samples
FRAC, 16, fractional bits of each per-sample relative error

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  pulse; latches num_samples and clears accumulators (honoured only in IDLE or DONE)
num_samples  input  CNT_W  number of pairs to score
in_valid  input  1  exact/apprx valid
in_ready  output  1  block accepts a pair this cycle
exact  input  W  reference product (unsigned)
apprx  input  W  approximate product (unsigned)
busy  output  1  high in ACCEPT or DIV
done  output  1  level; high in DONE until next start or reset
sample_count  output  CNT_W  pairs accepted so far
err_count  output  CNT_W  pairs with exact != apprx
sum_ed_abs  output  W+CNT_W  sum of |exact-apprx|
sum_ed_signed  output  W+CNT_W+1  two's-complement sum of (exact-apprx)
max_ed  output  W  max |exact-apprx|
sum_re  output  W+FRAC+CNT_W  sum of floor((|exact-apprx| << FRAC) / exact); 0 term when exact==0

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including in_ready, busy and done.
- States: IDLE, ACCEPT, DIV, DONE.
- IDLE/DONE + start:
  - Clear all accumulators, sample_count and max_ed; latch num_samples.
  - Next state is ACCEPT, or DONE if num_samples==0. In that case done=1 on the next cycle with all results 0.
- start in ACCEPT/DIV is ignored.
- ACCEPT: in_ready=1. A handshake (in_valid & in_ready) on cycle k does the following, all registered at the end of cycle k:
  - ed = |exact-apprx| (W bits); d = exact-apprx (W+1 signed).
  - sample_count += 1.
  - err_count += (ed!=0).
  - sum_ed_abs += ed; sum_ed_signed += sign-extended d.
  - max_ed = ed if ed > max_ed (ties: no change).
  - If ed!=0 and exact!=0: go to DIV.
  - Else: relative-error term is 0. Stay in ACCEPT (back-to-back accepts allowed), or go to DONE if this was sample num_samples.
- DIV: in_ready=0.
  - Restoring divider of (ed << FRAC) by the latched exact, one quotient bit per cycle, W+FRAC cycles (k+1 .. k+W+FRAC).
  - The quotient is added to sum_re at the end of the last DIV cycle.
  - Next state is ACCEPT (in_ready=1 on cycle k+W+FRAC+1), or DONE if this was the last sample.
- in_valid low in ACCEPT: hold, no state change.
- DONE: done=1, busy=0, in_ready=0; results held stable.
- Widths guarantee no overflow for num_samples <= 2^CNT_W-1. No saturation logic.
- Reset mid-operation (any state, including mid-DIV): immediate return to IDLE, all outputs 0, partial division discarded.

Test Plan:
- Reset, then start with num_samples=3; pairs (100,100), (0,0), (65535,65535) with in_valid held high -> in_ready never drops, 3 consecutive accepts; done=1 the cycle after the 3rd accept; err_count=0, sums=0, max_ed=0, sum_re=0, sample_count=3.
- num_samples=1, pair (1000,996) -> in_ready low for exactly 32 cycles after accept; then done=1, err_count=1, sum_ed_abs=4, sum_ed_signed=+4, max_ed=4, sum_re=262.
- num_samples=1, pair (0,5) -> no DIV stall; err_count=1, sum_ed_abs=5, sum_ed_signed=-5, max_ed=5, sum_re=0.
- num_samples=2, pairs (10,20), (200,150), with in_valid dropped for 3 cycles between them -> sum_ed_signed=40, sum_ed_abs=60, max_ed=50, err_count=2, sum_re=65536+16384=81920; the gap causes no extra accept.
- start with num_samples=0 -> done=1 on the next cycle, all results 0. Then start with num_samples=2, and pulse start again during the first DIV -> the second pulse is ignored; final sample_count=2.
- Assert rst_n=0 mid-DIV -> all outputs 0 immediately, state IDLE. After release, a fresh start with pair (1000,996) reproduces the scenario-2 results exactly.

Source files
------------

// File: rtl/err_metric_accum.sv
// err_metric_accum
//   Error-metric engine for approximate-multiplier characterisation. Scores a
//   stream of (exact, apprx) product pairs and accumulates error count,
//   signed/absolute error-distance sums, max absolute error and a fixed-point
//   relative-error sum. Software divides by the sample count to get
//   ER, MED, MNED and MRED.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start, num_samples  start a run of num_samples pairs (IDLE/DONE only)
//   in_valid, in_ready  pair handshake
//   exact, apprx        reference and approximate products (unsigned)
//   busy, done          run status (done is a level held until next start)
//   sample_count        pairs accepted
//   err_count           pairs with exact != apprx
//   sum_ed_abs          sum |exact-apprx|
//   sum_ed_signed       two's-complement sum (exact-apprx)
//   max_ed              max |exact-apprx|
//   sum_re              sum floor((|exact-apprx| << FRAC) / exact)
//
// State    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_ACCEPT | in_ready high, scoring pairs
// S_DIV    | serial divide of one relative-error term, in_ready low
// S_DONE   | run finished, results held, done high
module err_metric_accum #(
    parameter int W     = 16,
    parameter int CNT_W = 32,
    parameter int FRAC  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_samples,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            exact,
    input  logic [W-1:0]            apprx,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        sample_count,
    output logic [CNT_W-1:0]        err_count,
    output logic [W+CNT_W-1:0]      sum_ed_abs,
    output logic [W+CNT_W:0]        sum_ed_signed,
    output logic [W-1:0]            max_ed,
    output logic [W+FRAC+CNT_W-1:0] sum_re
);

    localparam int DIV_N  = W + FRAC;
    localparam int CNT_DW = $clog2(DIV_N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_DIV    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]        r_num;
    logic [CNT_W-1:0]        r_sample_count;
    logic [CNT_W-1:0]        r_err_count;
    logic [W+CNT_W-1:0]      r_sum_ed_abs;
    logic [W+CNT_W:0]        r_sum_ed_signed;
    logic [W-1:0]            r_max_ed;
    logic [W+FRAC+CNT_W-1:0] r_sum_re;

    // serial divider state
    logic [W-1:0]            r_div;
    logic [W-1:0]            r_rem;
    logic [DIV_N-1:0]        r_dvd;
    logic [DIV_N-2:0]        r_quo;
    logic [CNT_DW-1:0]       r_cnt;

    logic                    w_start_ok;
    logic                    w_hs;
    logic [W-1:0]            w_ed;
    logic [W:0]              w_d;
    logic                    w_ed_nz;
    logic                    w_div_go;
    logic                    w_last_acc;
    logic                    w_div_end;
    logic [W:0]              w_rem_shift;
    logic                    w_qbit;
    logic [W-1:0]            w_rem_sub;
    logic [W-1:0]            w_rem_nxt;
    logic [DIV_N-1:0]        w_quo_final;

    assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_hs       = in_valid & (r_state == S_ACCEPT);
    assign w_ed       = (exact >= apprx) ? (exact - apprx) : (apprx - exact);
    assign w_d        = {1'b0, exact} - {1'b0, apprx};
    assign w_ed_nz    = |w_ed;
    assign w_div_go   = w_ed_nz & (|exact);
    assign w_last_acc = (r_sample_count + CNT_W'(1)) == r_num;
    assign w_div_end  = (r_state == S_DIV) && (r_cnt == '0);

    // Restoring divide step. The shifted remainder is < 2*divisor, so when it
    // is >= divisor the true difference fits in W bits and the modular W-bit
    // subtraction is exact.
    assign w_rem_shift = {r_rem, r_dvd[DIV_N-1]};
    assign w_qbit      = w_rem_shift >= {1'b0, r_div};
    assign w_rem_sub   = w_rem_shift[W-1:0] - r_div;
    assign w_rem_nxt   = w_qbit ? w_rem_sub : w_rem_shift[W-1:0];
    assign w_quo_final = {r_quo, w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_nxt = (num_samples == '0) ? S_DONE : S_ACCEPT;
            end
            S_ACCEPT: begin
                if (w_hs) begin
                    if (w_div_go)        w_state_nxt = S_DIV;
                    else if (w_last_acc) w_state_nxt = S_DONE;
                end
            end
            S_DIV: begin
                // sample_count already includes the sample being divided
                if (w_div_end) w_state_nxt = (r_sample_count == r_num) ? S_DONE : S_ACCEPT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num           <= '0;
            r_sample_count  <= '0;
            r_err_count     <= '0;
            r_sum_ed_abs    <= '0;
            r_sum_ed_signed <= '0;
            r_max_ed        <= '0;
            r_sum_re        <= '0;
            r_div           <= '0;
            r_rem           <= '0;
            r_dvd           <= '0;
            r_quo           <= '0;
            r_cnt           <= '0;
        end else begin
            if (w_start_ok) begin
                r_num           <= num_samples;
                r_sample_count  <= '0;
                r_err_count     <= '0;
                r_sum_ed_abs    <= '0;
                r_sum_ed_signed <= '0;
                r_max_ed        <= '0;
                r_sum_re        <= '0;
            end

            if (w_hs) begin
                r_sample_count  <= r_sample_count + CNT_W'(1);
                r_err_count     <= r_err_count + {{(CNT_W-1){1'b0}}, w_ed_nz};
                r_sum_ed_abs    <= r_sum_ed_abs + {{CNT_W{1'b0}}, w_ed};
                r_sum_ed_signed <= r_sum_ed_signed + {{CNT_W{w_d[W]}}, w_d};
                if (w_ed > r_max_ed) r_max_ed <= w_ed;
                if (w_div_go) begin
                    r_div <= exact;
                    r_rem <= '0;
                    r_dvd <= {w_ed, {FRAC{1'b0}}};
                    r_quo <= '0;
                    r_cnt <= CNT_DW'(DIV_N - 1);
                end
            end

            if (r_state == S_DIV) begin
                r_rem <= w_rem_nxt;
                r_dvd <= {r_dvd[DIV_N-2:0], 1'b0};
                r_quo <= w_quo_final[DIV_N-2:0];
                r_cnt <= r_cnt - CNT_DW'(1);
                if (w_div_end) r_sum_re <= r_sum_re + {{CNT_W{1'b0}}, w_quo_final};
            end
        end
    end

    assign in_ready      = (r_state == S_ACCEPT);
    assign busy          = (r_state == S_ACCEPT) | (r_state == S_DIV);
    assign done          = (r_state == S_DONE);
    assign sample_count  = r_sample_count;
    assign err_count     = r_err_count;
    assign sum_ed_abs    = r_sum_ed_abs;
    assign sum_ed_signed = r_sum_ed_signed;
    assign max_ed        = r_max_ed;
    assign sum_re        = r_sum_re;

endmodule
